// File: rtl/seg_scan_scheduler.sv
// Multiplexed 8-digit 7-segment scan scheduler: blank guard + PWM on-time per slot, frame-latched data.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan_scheduler #(
    parameter int TICK_DIV    = 390,
    parameter int BLANK_TICKS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] digits_in,
    input  logic [7:0]  dp_in,
    input  logic [3:0]  brightness,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n,
    output logic [2:0]  digit_sel,
    output logic        frame_start
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [4:0]       BLANK_5  = 5'(BLANK_TICKS);
    // The final sub-tick of every slot is kept dark so the next slot's glyph load
    // never coincides with an anode edge.
    localparam logic [4:0]       ON_LIMIT = 5'(15 - BLANK_TICKS);

    typedef enum logic [1:0] {IDLE, BLANK, ON, OFF} state_t;

    state_t           state;
    state_t           state_next;
    logic [PRE_W-1:0] pre;
    logic [3:0]       phase;
    logic [4:0]       ph_next;

    logic [31:0] digits_lat;
    logic [7:0]  dp_lat;
    logic [3:0]  bright_lat;
    logic [7:0]  blank_lat;

    logic        tick;
    logic        slot_end;
    logic        slot_begin;
    logic        latch;
    logic [2:0]  digit_next;
    logic [2:0]  an_idx;
    logic [31:0] src_digits;
    logic [7:0]  src_dp;
    logic [3:0]  src_bright;
    logic [7:0]  src_blank;
    logic [7:0]  in_blank;
    logic [3:0]  load_nib;
    logic [6:0]  load_seg;
    logic        load_dp;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // Digit k (k>=1) is blank when it and every higher digit are zero.
    function automatic logic [7:0] leading_blank(input logic [31:0] d);
        logic       run;
        logic [7:0] m;
        run = 1'b1;
        m   = '0;
        for (int k = 7; k >= 1; k--) begin
            run  = run && (d[4*k +: 4] == 4'd0);
            m[k] = run;
        end
        return m;
    endfunction

    function automatic state_t slot_state(input logic [4:0] ph, input logic [3:0] br);
        logic [4:0] on_t;
        on_t = ({1'b0, br} < ON_LIMIT) ? {1'b0, br} : ON_LIMIT;
        if (ph < BLANK_5)             return BLANK;
        else if (ph < BLANK_5 + on_t) return ON;
        else                          return OFF;
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        tick       = (state != IDLE) && (pre == PRE_MAX);
        slot_end   = tick && (phase == 4'd15);
        slot_begin = (state == IDLE) || slot_end;
        digit_next = (state == IDLE) ? 3'd0 : digit_sel + 3'd1;
        latch      = enable && ((state == IDLE) || (slot_end && digit_next == 3'd0));

`ifdef SEG_LEADING_ZERO_BLANK_EN
        in_blank = leading_blank(digits_in);
`else
        in_blank = 8'h00;
`endif

        // At a frame boundary the new inputs are shown directly while they are captured.
        src_digits = latch ? digits_in  : digits_lat;
        src_dp     = latch ? dp_in      : dp_lat;
        src_bright = latch ? brightness : bright_lat;
        src_blank  = latch ? in_blank   : blank_lat;

        load_nib = src_digits[{digit_next, 2'b00} +: 4];
        load_seg = src_blank[digit_next] ? 7'h7F : glyph(load_nib);
        load_dp  = src_blank[digit_next] | ~src_dp[digit_next];

        ph_next    = (state == IDLE) ? 5'd0 : {1'b0, phase + 4'd1};
        state_next = slot_state(ph_next, src_bright);
        an_idx     = slot_begin ? digit_next : digit_sel;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pre         <= '0;
            phase       <= 4'd0;
            digit_sel   <= 3'd0;
            an_n        <= 8'hFF;
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
            // NOTE: shadow registers are reset too, so no X can reach the pins after reset.
            digits_lat  <= '0;
            dp_lat      <= '0;
            bright_lat  <= '0;
            blank_lat   <= '0;
        end else if (!enable) begin
            state       <= IDLE;
            pre         <= '0;
            phase       <= 4'd0;
            digit_sel   <= 3'd0;
            an_n        <= 8'hFF;
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= latch;
            if (latch) begin
                digits_lat <= digits_in;
                dp_lat     <= dp_in;
                bright_lat <= brightness;
                blank_lat  <= in_blank;
            end

            if (state == IDLE || tick) begin
                state <= state_next;
                phase <= ph_next[3:0];
                pre   <= '0;
                an_n  <= (state_next == ON) ? ~(8'd1 << an_idx) : 8'hFF;
            end else begin
                pre <= pre + PRE_W'(1);
            end

            if (slot_begin) begin
                digit_sel <= digit_next;
                seg_n     <= load_seg;
                dp_n      <= load_dp;
            end
        end
    end

endmodule
